star_bbox_finder: RTL

STAR_BBOX_FINDER -- requirements
Module: star_bbox_finder

---
 rtl/star_bbox_finder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/star_bbox_finder.sv
// star_bbox_finder: measures the inclusive bounding box of a lit blob by probing outward from a seed pixel.
// Optional macro STAR_BBOX_MIDCOL_SCAN_EN: vertical scans use the horizontal midpoint column instead of the seed column.
module star_bbox_finder #(
    parameter int IMG_W     = 6,
    parameter int IMG_H     = 6,
    parameter int PIX_W     = 3,
    parameter int THRESHOLD = 0,
    localparam int X_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int Y_W      = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int ADDR_W   = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [X_W-1:0]    x_in,
    input  logic [Y_W-1:0]    y_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              empty,
    output logic [X_W-1:0]    left,
    output logic [X_W-1:0]    right,
    output logic [Y_W-1:0]    top,
    output logic [Y_W-1:0]    bottom,
    output logic [X_W-1:0]    mid_x,
    output logic [Y_W-1:0]    mid_y
);

    localparam logic [X_W-1:0]   X_MAX = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_MAX = Y_W'(IMG_H - 1);
    localparam logic [PIX_W-1:0] THR   = PIX_W'(THRESHOLD);

    typedef enum logic [2:0] {IDLE, SEED, RIGHT, LEFT, DOWN, UP, DONE} state_t;

    state_t              state_q, state_d, cand;
    logic                phase_q, phase_d;   // 0: address cycle, 1: compare cycle
    logic [X_W-1:0]      seed_x_q, seed_x_d;
    logic [Y_W-1:0]      seed_y_q, seed_y_d;
    logic [X_W-1:0]      left_q, left_d, right_q, right_d, scan_col;
    logic [Y_W-1:0]      top_q, top_d, bottom_q, bottom_d;
    logic                empty_q, empty_d, lit, advance;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [X_W:0]        sum_x, sum_scan;
    logic [Y_W:0]        sum_y;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
    endfunction

    assign lit      = (mem_rdata > THR);
    assign sum_scan = {1'b0, left_d} + {1'b0, right_d};

`ifdef STAR_BBOX_MIDCOL_SCAN_EN
    assign scan_col = sum_scan[X_W:1];
`else
    assign scan_col = seed_x_q;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        seed_x_d   = seed_x_q;
        seed_y_d   = seed_y_q;
        left_d     = left_q;
        right_d    = right_q;
        top_d      = top_q;
        bottom_d   = bottom_q;
        empty_d    = empty_q;
        mem_addr_d = mem_addr_q;
        advance    = 1'b0;
        cand       = DONE;

        case (state_q)
            IDLE: if (start) begin
                seed_x_d   = x_in;
                seed_y_d   = y_in;
                left_d     = x_in;
                right_d    = x_in;
                top_d      = y_in;
                bottom_d   = y_in;
                empty_d    = 1'b0;
                state_d    = SEED;
                phase_d    = 1'b0;
                mem_addr_d = addr_of(x_in, y_in);
            end
            SEED: if (!phase_q) begin
                phase_d = 1'b1;
            end else if (!lit) begin
                empty_d = 1'b1;
                state_d = DONE;
            end else begin
                advance = 1'b1;
                cand    = RIGHT;
            end
            RIGHT: if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                advance = 1'b1;
                cand    = lit ? RIGHT : LEFT;
                if (lit) right_d = right_q + X_W'(1);
            end
            LEFT: if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                advance = 1'b1;
                cand    = lit ? LEFT : DOWN;
                if (lit) left_d = left_q - X_W'(1);
            end
            DOWN: if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                advance = 1'b1;
                cand    = lit ? DOWN : UP;
                if (lit) bottom_d = bottom_q + Y_W'(1);
            end
            UP: if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                advance = 1'b1;
                cand    = lit ? UP : DONE;
                if (lit) top_d = top_q - Y_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Skip any direction already at the image edge so boundary stops cost no cycles.
        if (advance) begin
            phase_d = 1'b0;
            if (cand == RIGHT && right_d != X_MAX) begin
                state_d    = RIGHT;
                mem_addr_d = addr_of(right_d + X_W'(1), seed_y_q);
            end else if (cand inside {RIGHT, LEFT} && left_d != '0) begin
                state_d    = LEFT;
                mem_addr_d = addr_of(left_d - X_W'(1), seed_y_q);
            end else if (cand inside {RIGHT, LEFT, DOWN} && bottom_d != Y_MAX) begin
                state_d    = DOWN;
                mem_addr_d = addr_of(scan_col, bottom_d + Y_W'(1));
            end else if (cand inside {RIGHT, LEFT, DOWN, UP} && top_d != '0) begin
                state_d    = UP;
                mem_addr_d = addr_of(scan_col, top_d - Y_W'(1));
            end else begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            seed_x_q   <= '0;
            seed_y_q   <= '0;
            left_q     <= '0;
            right_q    <= '0;
            top_q      <= '0;
            bottom_q   <= '0;
            empty_q    <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            seed_x_q   <= seed_x_d;
            seed_y_q   <= seed_y_d;
            left_q     <= left_d;
            right_q    <= right_d;
            top_q      <= top_d;
            bottom_q   <= bottom_d;
            empty_q    <= empty_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign sum_x    = {1'b0, left_q} + {1'b0, right_q};
    assign sum_y    = {1'b0, top_q} + {1'b0, bottom_q};
    assign mid_x    = sum_x[X_W:1];
    assign mid_y    = sum_y[Y_W:1];
    assign mem_addr = mem_addr_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign empty    = empty_q;
    assign left     = left_q;
    assign right    = right_q;
    assign top      = top_q;
    assign bottom   = bottom_q;

endmodule
